// File: rtl/lsu_bus_if_pkg.sv
// Shared constants, state type and helpers for the load/store bus initiator.
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN (widens the lane datapath to two words).
package lsu_bus_if_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] ZEROWORD = '0;

   localparam logic [1:0] LSU_SIZE_B = 2'b00;
   localparam logic [1:0] LSU_SIZE_H = 2'b01;
   localparam logic [1:0] LSU_SIZE_W = 2'b10;

   localparam logic [XLEN-1:0] LSU_IDLE_ADDR = 32'hFFFF_FFFC;

`ifdef LSU_MISALIGNED_SPLIT_EN
   localparam int LANES = 8;
   typedef enum logic [2:0] {IDLE, ACCESS, WAIT, ACCESS1, WAIT1} lsu_state_e;
`else
   localparam int LANES = 4;
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT} lsu_state_e;
`endif
   localparam int DW = LANES * 8;

   // Byte-lane mask of an access at offset 0; size 11 behaves as a word.
   function automatic logic [3:0] sizeMask(input logic [1:0] size);
      case (size)
         LSU_SIZE_B: sizeMask = 4'b0001;
         LSU_SIZE_H: sizeMask = 4'b0011;
         default:    sizeMask = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: write mask/data placement, load shift/extension and odd-access detect.
// With LSU_MISALIGNED_SPLIT_EN, odd_o flags a word-crossing access; otherwise it flags misalignment.
module lsu_align
   import lsu_bus_if_pkg::*;
(
   input  logic [1:0]       off_i,
   input  logic [1:0]       size_i,
   input  logic             unsigned_i,
   input  logic [XLEN-1:0]  st_data_i,
   input  logic [DW-1:0]    ld_data_i,
   output logic             odd_o,
   output logic [LANES-1:0] mask_o,
   output logic [DW-1:0]    st_data_o,
   output logic [XLEN-1:0]  ld_data_o
);

   logic [XLEN-1:0] ldShift;
`ifdef LSU_MISALIGNED_SPLIT_EN
   logic [2:0]      nBytes;
   logic [XLEN-1:0] stSized;
`endif

   always_comb begin
      mask_o = LANES'(sizeMask(size_i)) << off_i;
`ifdef LSU_MISALIGNED_SPLIT_EN
      nBytes  = 3'd4;
      stSized = st_data_i;
      case (size_i)
         LSU_SIZE_B: begin nBytes = 3'd1; stSized = {24'b0, st_data_i[7:0]};  end
         LSU_SIZE_H: begin nBytes = 3'd2; stSized = {16'b0, st_data_i[15:0]}; end
         default: ;
      endcase
      odd_o     = ({1'b0, off_i} + nBytes) > 3'd4;
      st_data_o = DW'(stSized) << {off_i, 3'b000};
`else
      // Replicated data lets both lane-positioned and LSB-positioned responders work.
      case (size_i)
         LSU_SIZE_B: begin odd_o = 1'b0;             st_data_o = {4{st_data_i[7:0]}};  end
         LSU_SIZE_H: begin odd_o = off_i[0];         st_data_o = {2{st_data_i[15:0]}}; end
         default:    begin odd_o = (off_i != 2'b00); st_data_o = st_data_i;            end
      endcase
`endif
      ldShift = XLEN'(ld_data_i >> {off_i, 3'b000});
      case (size_i)
         LSU_SIZE_B: ld_data_o = unsigned_i ? {24'b0, ldShift[7:0]}  : {{24{ldShift[7]}}, ldShift[7:0]};
         LSU_SIZE_H: ld_data_o = unsigned_i ? {16'b0, ldShift[15:0]} : {{16{ldShift[15]}}, ldShift[15:0]};
         default:    ld_data_o = ldShift;
      endcase
   end

endmodule

// File: rtl/lsu_bus_if.sv
// Load/store initiator: one request at a time, registered bus strobes, one-cycle response pulse.
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN (split word-crossing accesses instead of erroring).
module lsu_bus_if
   import lsu_bus_if_pkg::*;
#(
   parameter logic [XLEN-1:0] IDLE_ADDR = LSU_IDLE_ADDR
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [XLEN-1:0] req_addr,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err,
   output logic [XLEN-1:0] raddr,
   output logic            re,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] waddr,
   output logic [3:0]      byte_we,
   output logic [XLEN-1:0] wdata
);

   lsu_state_e state_q, state_d;

   logic            reqWe_q, reqUns_q;
   logic [XLEN-1:0] reqAddr_q, reqData_q;
   logic [1:0]      reqSize_q;

   logic            re_q, re_d, rspValid_q, rspValid_d, rspErr_q, rspErr_d;
   logic [XLEN-1:0] raddr_q, raddr_d, waddr_q, waddr_d, wdata_q, wdata_d;
   logic [XLEN-1:0] rspRdata_q, rspRdata_d;
   logic [3:0]      bwe_q, bwe_d;

   logic             accept, odd, errReq;
   logic [XLEN-1:0]  curAddr, curData, baseAddr, ldResult;
   logic [1:0]       curSize;
   logic [LANES-1:0] mask;
   logic [DW-1:0]    stLanes, ldLanes;

   assign req_ready = (state_q == IDLE);
   assign accept    = req_valid & req_ready;

   // The aligner sees the incoming request while idle and the held request afterwards.
   assign curAddr  = req_ready ? req_addr  : reqAddr_q;
   assign curSize  = req_ready ? req_size  : reqSize_q;
   assign curData  = req_ready ? req_wdata : reqData_q;
   assign baseAddr = {curAddr[XLEN-1:2], 2'b00};

`ifdef LSU_MISALIGNED_SPLIT_EN
   logic [XLEN-1:0] rdata0_q;
   logic [XLEN-1:0] nextAddr;
   assign nextAddr = baseAddr + 32'd4;
   assign errReq   = 1'b0;
   assign ldLanes  = (state_q == WAIT1) ? {rdata, rdata0_q} : {ZEROWORD, rdata};

   always_ff @(posedge clk) begin
      if (!rst_n)
         rdata0_q <= ZEROWORD;
      else if (state_q == WAIT)
         rdata0_q <= rdata;
   end
`else
   assign errReq  = odd;
   assign ldLanes = rdata;
`endif

   lsu_align u_align (
      .off_i      (curAddr[1:0]),
      .size_i     (curSize),
      .unsigned_i (reqUns_q),
      .st_data_i  (curData),
      .ld_data_i  (ldLanes),
      .odd_o      (odd),
      .mask_o     (mask),
      .st_data_o  (stLanes),
      .ld_data_o  (ldResult)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reqWe_q   <= 1'b0;
         reqUns_q  <= 1'b0;
         reqAddr_q <= ZEROWORD;
         reqData_q <= ZEROWORD;
         reqSize_q <= LSU_SIZE_B;
      end else if (accept) begin
         reqWe_q   <= req_we;
         reqUns_q  <= req_unsigned;
         reqAddr_q <= req_addr;
         reqData_q <= req_wdata;
         reqSize_q <= req_size;
      end
   end

   // Reset abandons any in-flight access, so no response pulse can follow it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         re_q       <= 1'b0;
         raddr_q    <= ZEROWORD;
         waddr_q    <= IDLE_ADDR;
         bwe_q      <= 4'b0000;
         wdata_q    <= ZEROWORD;
         rspValid_q <= 1'b0;
         rspErr_q   <= 1'b0;
         rspRdata_q <= ZEROWORD;
      end else begin
         state_q    <= state_d;
         re_q       <= re_d;
         raddr_q    <= raddr_d;
         waddr_q    <= waddr_d;
         bwe_q      <= bwe_d;
         wdata_q    <= wdata_d;
         rspValid_q <= rspValid_d;
         rspErr_q   <= rspErr_d;
         rspRdata_q <= rspRdata_d;
      end
   end

   // Bus strobes are computed one state early so they are registered into the ACCESS cycle.
   always_comb begin
      state_d    = state_q;
      re_d       = 1'b0;
      raddr_d    = raddr_q;
      waddr_d    = IDLE_ADDR;
      bwe_d      = 4'b0000;
      wdata_d    = wdata_q;
      rspValid_d = 1'b0;
      rspErr_d   = 1'b0;
      rspRdata_d = rspRdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (errReq) begin
                  rspValid_d = 1'b1;
                  rspErr_d   = 1'b1;
                  rspRdata_d = ZEROWORD;
               end else begin
                  state_d = ACCESS;
                  if (req_we) begin
                     waddr_d = baseAddr;
                     bwe_d   = mask[3:0];
                     wdata_d = stLanes[31:0];
                  end else begin
                     re_d    = 1'b1;
                     raddr_d = baseAddr;
                  end
               end
            end
         end
         ACCESS: begin
            if (reqWe_q) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
               if (odd) begin
                  state_d = ACCESS1;
                  waddr_d = nextAddr;
                  bwe_d   = mask[7:4];
                  wdata_d = stLanes[63:32];
               end else
`endif
               begin
                  state_d    = IDLE;
                  rspValid_d = 1'b1;
                  rspRdata_d = ZEROWORD;
               end
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
            if (odd) begin
               state_d = ACCESS1;
               re_d    = 1'b1;
               raddr_d = nextAddr;
            end else
`endif
            begin
               state_d    = IDLE;
               rspValid_d = 1'b1;
               rspRdata_d = ldResult;
            end
         end
`ifdef LSU_MISALIGNED_SPLIT_EN
         ACCESS1: begin
            if (reqWe_q) begin
               state_d    = IDLE;
               rspValid_d = 1'b1;
               rspRdata_d = ZEROWORD;
            end else begin
               state_d = WAIT1;
            end
         end
         WAIT1: begin
            state_d    = IDLE;
            rspValid_d = 1'b1;
            rspRdata_d = ldResult;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign re        = re_q;
   assign raddr     = raddr_q;
   assign waddr     = waddr_q;
   assign byte_we   = bwe_q;
   assign wdata     = wdata_q;
   assign rsp_valid = rspValid_q;
   assign rsp_err   = rspErr_q;
   assign rsp_rdata = rspRdata_q;

endmodule
